cordic_rot_core: RTL and testbench

Iterative rotation-mode CORDIC engine that computes cos/sin of a signed angle, one micro-rotation per clock over 23 iterations. It sits directly downstream of the arctangent lookup table. It drives the table's 6-bit iteration index and consumes the 25-bit atan(2^-i) constant it returns combinationally. Results go to the trig consumer through a valid/ready output handshake.

---
 rtl/cordic_rot_core.sv | 174 +++++++++++++++++
 tb/tb_cordic_rot_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rot_core.sv
// -----------------------------------------------------------------------------
// cordic_rot_core
//
// Iterative rotation-mode CORDIC engine. Takes a signed Q2.23 angle and
// produces cos/sin (Q2.23) by performing one micro-rotation per clock for
// ITER iterations. The arctangent constants come from an external,
// purely combinational LUT addressed by lut_num.
//
// Build option:
//   CORDIC_GAIN_COMP_EN  defined   -> start vector x = K (0.6072529), so the
//                                     results have unit magnitude.
//                        undefined -> start vector x = 1.0, so the results
//                                     carry the CORDIC gain (~1.6467602).
//   Only the start value changes; timing and interface are identical.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   angle request valid
//   in_ready   core can accept an angle (high only while idle)
//   in_theta   signed angle, Q2.23 (LSB = 2^-23 rad)
//   lut_num    iteration index to the atan LUT (registered)
//   lut_atan   atan(2^-lut_num) in Q2.23, combinational from lut_num
//   out_valid  result valid, held until accepted
//   out_ready  consumer accepts the result
//   out_cos    x result, Q2.23
//   out_sin    y result, Q2.23
//   out_zres   residual angle after the last iteration
//   out_err    input angle was outside the convergence range
// -----------------------------------------------------------------------------
module cordic_rot_core #(
  parameter int ITER = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_theta,
  output logic [5:0]  lut_num,
  input  logic [24:0] lut_atan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_cos,
  output logic [24:0] out_sin,
  output logic [24:0] out_zres,
  output logic        out_err
);

  localparam int W = 25;

`ifdef CORDIC_GAIN_COMP_EN
  // K = 0.6072529 in Q2.23: pre-scaling by the inverse gain.
  localparam logic signed [W-1:0] X0 = 25'sd5094007;
`else
  // 1.0 in Q2.23: the consumer removes the CORDIC gain itself.
  localparam logic signed [W-1:0] X0 = 25'sd8388608;
`endif

  // Sum of atan(2^-i), i = 0..22, in Q2.23 (~1.7432866 rad).
  localparam logic [W-1:0] ERR_LIM = 25'd14623748;
  localparam logic [5:0]   LAST    = 6'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic signed [W-1:0]   x_reg, x_next;
  logic signed [W-1:0]   y_reg, y_next;
  logic signed [W-1:0]   z_reg, z_next;
  logic [5:0]            iter_reg, iter_next;
  logic                  err_reg, err_next;

  logic [W-1:0]          theta_abs;
  logic                  theta_oor;
  logic signed [W-1:0]   x_sh, y_sh;
  logic signed [W-1:0]   atan_s;
  logic                  d_pos;

  // Magnitude of the request angle. The most negative code maps to 2^24,
  // which still reads correctly as an unsigned 25-bit number.
  assign theta_abs = in_theta[W-1] ? (~in_theta + 25'd1) : in_theta;
  assign theta_oor = (theta_abs > ERR_LIM);

  assign x_sh   = x_reg >>> iter_reg;
  assign y_sh   = y_reg >>> iter_reg;
  assign atan_s = $signed(lut_atan);
  assign d_pos  = ~z_reg[W-1];        // rotate positively while z >= 0

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      iter_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      z_reg     <= z_next;
      iter_reg  <= iter_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    iter_next  = iter_reg;
    err_next   = err_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          x_next     = X0;
          y_next     = '0;
          z_next     = $signed(in_theta);
          iter_next  = '0;
          err_next   = theta_oor;
          state_next = ST_ITER;
        end
      end

      ST_ITER: begin
        if (d_pos) begin
          x_next = x_reg - y_sh;
          y_next = y_reg + x_sh;
          z_next = z_reg - atan_s;
        end else begin
          x_next = x_reg + y_sh;
          y_next = y_reg - x_sh;
          z_next = z_reg + atan_s;
        end
        // iter returns to 0 on exit so it can double as the LUT index,
        // which must read 0 outside the iteration phase.
        if (iter_reg == LAST) begin
          iter_next  = '0;
          state_next = ST_DONE;
        end else begin
          iter_next  = iter_reg + 6'd1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // iter_reg is a flop and is held at 0 outside ST_ITER, so the LUT index
  // is glitch-free and needs no extra decode.
  assign lut_num   = iter_reg;
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign out_cos   = x_reg;
  assign out_sin   = y_reg;
  assign out_zres  = z_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_cordic_rot_core.sv
// -----------------------------------------------------------------------------
// tb_cordic_rot_core
//
// Directed bench for cordic_rot_core. Provides the atan LUT as a
// combinational function of lut_num, then walks a fixed sequence of angle
// requests, checking latency, LUT indexing, results, back-pressure and
// mid-operation reset. Expected magnitudes follow CORDIC_GAIN_COMP_EN.
// -----------------------------------------------------------------------------
module tb_cordic_rot_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_theta;
  logic [5:0]  lut_num;
  logic [24:0] lut_atan;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_cos;
  logic [24:0] out_sin;
  logic [24:0] out_zres;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_rot_core #(.ITER(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_theta  (in_theta),
    .lut_num   (lut_num),
    .lut_atan  (lut_atan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .out_zres  (out_zres),
    .out_err   (out_err)
  );

  // round(atan(2^-n) * 2^23)
  function automatic logic [24:0] atan_lut(input logic [5:0] n);
    logic [24:0] one;
    one = 25'd1;
    case (n)
      6'd0:    atan_lut = 25'd6588397;
      6'd1:    atan_lut = 25'd3889358;
      6'd2:    atan_lut = 25'd2055030;
      6'd3:    atan_lut = 25'd1043165;
      6'd4:    atan_lut = 25'd523607;
      6'd5:    atan_lut = 25'd262059;
      6'd6:    atan_lut = 25'd131061;
      6'd7:    atan_lut = 25'd65535;
      6'd8:    atan_lut = 25'd32768;
      6'd9:    atan_lut = 25'd16384;
      default: atan_lut = (n <= 6'd23) ? (one << (6'd23 - n)) : 25'd0;
    endcase
  endfunction

  assign lut_atan = atan_lut(lut_num);

  // Full-scale result magnitude and its cos(pi/4) share, Q2.23.
  // Gain of 23 stages is 1.6467602581, so 1.0 * gain = 13814026.
`ifdef CORDIC_GAIN_COMP_EN
  localparam longint MAG  = 8388608;
  localparam longint DIAG = 5931642;
`else
  localparam longint MAG  = 13814026;
  localparam longint DIAG = 9767991;
`endif
  localparam longint TOL = 8;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint exp);
    longint d;
    checks++;
    d = obs - exp;
    assert (((d <= TOL) && (d >= -TOL)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, TOL);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid. Returns at the
  // falling edge where out_valid is first seen high.
  task automatic run_angle(input logic [24:0] theta, input string tag);
    int lat;
    @(negedge clk);
    check_eq({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_theta = theta;
    @(negedge clk);
    in_valid = 1'b0;
    in_theta = 25'h1555555;        // must not affect the running request
    lat = 0;
    while ((out_valid !== 1'b1) && (lat < 60)) begin
      if (lat < 23) check_eq({tag, "_lut_num"}, lut_num, lat);
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 23);
    check_eq({tag, "_lut_num_done"}, lut_num, 0);
    check_eq({tag, "_in_ready_busy"}, in_ready, 0);
    $display("txn %s: theta=%0d cos=%0d sin=%0d zres=%0d err=%0d lat=%0d",
             tag, $signed(theta), $signed(out_cos), $signed(out_sin),
             $signed(out_zres), out_err, lat);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_out_valid_after_hs"}, out_valid, 0);
    check_eq({tag, "_in_ready_after_hs"}, in_ready, 1);
  endtask

  initial begin : stim
    logic [24:0] snap_cos, snap_sin, snap_z;
    int w;
    int seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_theta  = '0;
    out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_cos", out_cos, 0);
    check_eq("rst_out_sin", out_sin, 0);
    check_eq("rst_out_zres", out_zres, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_lut_num", lut_num, 0);
    rst = 1'b0;

    // theta = 0
    run_angle(25'd0, "zero");
    check_near("zero_cos", $signed(out_cos), MAG);
    check_near("zero_sin", $signed(out_sin), 0);
    check_eq("zero_err", out_err, 0);
    handshake("zero");

    // theta = pi/4
    run_angle(25'd6588397, "pi4");
    check_near("pi4_cos", $signed(out_cos), DIAG);
    check_near("pi4_sin", $signed(out_sin), DIAG);
    check_eq("pi4_err", out_err, 0);
    handshake("pi4");

    // theta = -pi/2
    run_angle(-25'sd13176795, "mpi2");
    check_near("mpi2_cos", $signed(out_cos), 0);
    check_near("mpi2_sin", $signed(out_sin), -MAG);
    check_eq("mpi2_err", out_err, 0);
    handshake("mpi2");

    // Out-of-range angle plus back-pressure; in_valid while busy is ignored
    run_angle(25'd16000000, "oor");
    check_eq("oor_err", out_err, 1);
    snap_cos = out_cos;
    snap_sin = out_sin;
    snap_z   = out_zres;
    in_valid = 1'b1;
    in_theta = 25'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_cos_stable", out_cos, snap_cos);
      check_eq("bp_sin_stable", out_sin, snap_sin);
      check_eq("bp_zres_stable", out_zres, snap_z);
      check_eq("bp_err_stable", out_err, 1);
    end
    in_valid = 1'b0;
    handshake("oor");

    // Reset in the middle of iteration 10
    @(negedge clk);
    in_valid = 1'b1;
    in_theta = 25'd6588397;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while ((lut_num !== 6'd10) && (w < 40)) begin
      @(negedge clk);
      w++;
    end
    check_eq("mid_reach_iter10", lut_num, 10);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_lut_num", lut_num, 0);
    check_eq("mid_rst_out_cos", out_cos, 0);
    repeat (2) begin
      @(negedge clk);
      check_eq("mid_rst_lut_num_hold", lut_num, 0);
    end
    rst = 1'b0;
    seen_valid = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid++;
    end
    check_eq("mid_no_stale_valid", seen_valid, 0);
    $display("txn reset_mid_iter: stale_valid_cycles=%0d", seen_valid);

    run_angle(25'd0, "post_rst");
    check_near("post_rst_cos", $signed(out_cos), MAG);
    check_near("post_rst_sin", $signed(out_sin), 0);
    check_eq("post_rst_err", out_err, 0);
    handshake("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
